// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the byte FIFO and its burst read controller
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    localparam int FIFO_DEPTH = 128;
    localparam logic [CNT_W_DEF-1:0] FIFO_FULL_CNT  = CNT_W_DEF'(FIFO_DEPTH);
    localparam logic [CNT_W_DEF-1:0] FIFO_EMPTY_CNT = '0;

    // Burst length and issue counters must hold the largest legal burst (64).
    localparam int BURST_MAX = 64;
    localparam int LEN_W     = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry in-order skid buffer carrying a byte and a last-beat flag
module fifo_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic              head_last,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] hd_data;
    logic [DATA_W-1:0] tl_data;
    logic              hd_last;
    logic              tl_last;
    logic [1:0]        cnt;

    // The caller's credit scheme guarantees no push into a full buffer and no pop from an empty one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hd_data <= '0;
            tl_data <= '0;
            hd_last <= 1'b0;
            tl_last <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        hd_data <= push_data;
                        hd_last <= push_last;
                    end else begin
                        tl_data <= push_data;
                        tl_last <= push_last;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        hd_data <= tl_data;
                        hd_last <= tl_last;
                    end
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        hd_data <= tl_data;
                        hd_last <= tl_last;
                        tl_data <= push_data;
                        tl_last <= push_last;
                    end else begin
                        hd_data <= push_data;
                        hd_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = hd_data;
    assign head_valid = (cnt != 2'd0);
    assign head_last  = hd_last & head_valid;
    assign occ        = cnt;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops fixed or flush-sized bursts from the byte FIFO onto a valid/ready stream
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  fifo_counter,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              burst_done
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_nxt;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  issued_nxt;
    logic              flush_pend;
    logic              flush_pend_nxt;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        credit_use;
    logic              rd_last;

    assign pop        = m_valid & m_ready;
    // Entries held plus the byte arriving next cycle, less the one leaving now: never exceeds 2.
    assign credit_use = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_last    = (issued == len - LEN_W'(1));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            len           <= '0;
            issued        <= '0;
            flush_pend    <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            len           <= len_nxt;
            issued        <= issued_nxt;
            flush_pend    <= flush_pend_nxt;
            inflight      <= fifo_rd_en;
            inflight_last <= fifo_rd_en & rd_last;
        end
    end

    always_comb begin
        state_nxt      = state;
        len_nxt        = len;
        issued_nxt     = issued;
        flush_pend_nxt = flush_pend | flush;
        fifo_rd_en     = 1'b0;
        burst_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_counter >= CNT_W'(BURST_LEN)) begin
                    len_nxt    = LEN_W'(BURST_LEN);
                    issued_nxt = '0;
                    state_nxt  = ST_READ;
                end else if (flush_pend && fifo_counter != CNT_W'(FIFO_EMPTY_CNT)) begin
                    // Below threshold here, so the occupancy fits in a burst length.
                    len_nxt        = LEN_W'(fifo_counter);
                    issued_nxt     = '0;
                    flush_pend_nxt = flush;
                    state_nxt      = ST_READ;
                end else if (flush_pend) begin
                    flush_pend_nxt = flush;
                end
            end
            ST_READ: begin
                if (!fifo_empty && issued < len && credit_use < 3'd2) begin
                    fifo_rd_en = 1'b1;
                    issued_nxt = issued + LEN_W'(1);
                    if (issued + LEN_W'(1) == len) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    burst_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (fifo_data),
        .push_last  (inflight_last),
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .head_last  (m_last),
        .occ        (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed and random checks of fifo_burst_reader against a queue-based model
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic [CW-1:0] fifo_counter;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          flush;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          burst_done;

    fifo_burst_reader #(
        .DATA_W    (DW),
        .CNT_W     (CW),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_counter (fifo_counter),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .burst_done   (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         lens_q[$];
    int         beat_idx;
    int         popped;
    int         accepted;
    int         pass_cnt;
    int         check_cnt;
    bit         last_rd;
    bit         last_busy;
    bit         last_valid;

    bit thr_rd   [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    bit thr_valid[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    bit thr_busy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        check_cnt++;
        assert (obs === want) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        fifo_counter = CW'(fq.size());
        fifo_empty   = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then model the FIFO's registered read after the edge.
    task automatic tick();
        logic [7:0] eb;
        bit         el;
        @(negedge clk);
        chk("no_read_when_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
        last_rd    = fifo_rd_en;
        last_busy  = busy;
        last_valid = m_valid;
        if (m_valid && m_ready) begin
            chk("beat_expected", {31'd0, exp_q.size() != 0 && lens_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0 && lens_q.size() != 0) begin
                eb = exp_q.pop_front();
                el = (beat_idx == lens_q[0] - 1);
                chk("beat_data", {24'd0, m_data}, {24'd0, eb});
                chk("beat_last", {31'd0, m_last}, {31'd0, el});
                chk("beat_done", {31'd0, burst_done}, {31'd0, el});
                if (el) begin
                    void'(lens_q.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            accepted++;
        end else begin
            chk("done_without_beat", {31'd0, burst_done}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (last_rd && fq.size() != 0) begin
            fifo_data = fq.pop_front();
            popped++;
        end
        fifo_counter = CW'(fq.size());
        fifo_empty   = (fq.size() == 0);
    endtask

    task automatic run_until_idle(input int max_cyc, input bit rnd);
        int n;
        n = 0;
        while (n < max_cyc && !(lens_q.size() == 0 && !busy)) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("burst_finish_in_budget", {31'd0, n < max_cyc}, 32'd1);
    endtask

    initial begin
        logic [7:0] held;
        int         n;
        int         acc0;

        pass_cnt = 0; check_cnt = 0; beat_idx = 0; popped = 0; accepted = 0;
        rst = 1'b0; fifo_counter = '0; fifo_empty = 1'b1; fifo_data = '0;
        flush = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
        rst = 1'b1;
        m_ready = 1'b1;
        tick();

        // Threshold burst with exact cycle-level latency
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        lens_q.push_back(4);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("thr_rd_c%0d", i), {31'd0, last_rd}, {31'd0, thr_rd[i]});
            chk($sformatf("thr_valid_c%0d", i), {31'd0, last_valid}, {31'd0, thr_valid[i]});
            chk($sformatf("thr_busy_c%0d", i), {31'd0, last_busy}, {31'd0, thr_busy[i]});
        end
        chk("thr_burst_consumed", lens_q.size(), 32'd0);

        // Flush of a partial FIFO
        push_byte(8'hA0);
        push_byte(8'hA1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("below_threshold_idle", {31'd0, last_busy}, 32'd0);
        end
        lens_q.push_back(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        run_until_idle(30, 1'b0);

        // Flush with an empty FIFO
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_empty_busy", {31'd0, last_busy}, 32'd0);
            chk("flush_empty_rd", {31'd0, last_rd}, 32'd0);
        end

        // Backpressure mid-burst
        for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
        lens_q.push_back(4);
        acc0 = accepted;
        n = 0;
        while (accepted < acc0 + 1 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_first_beat_in_budget", {31'd0, n < 20}, 32'd1);
        m_ready = 1'b0;
        held = m_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rd_stalled", {31'd0, last_rd}, 32'd0);
            chk("bp_valid_held", {31'd0, last_valid}, 32'd1);
            chk("bp_data_stable", {24'd0, m_data}, {24'd0, held});
        end
        chk("bp_buffered_two", popped - accepted, 32'd2);
        m_ready = 1'b1;
        run_until_idle(30, 1'b0);

        // Random ready over 64 random bytes
        for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 64 / BL; i++) lens_q.push_back(BL);
        run_until_idle(2000, 1'b1);
        m_ready = 1'b1;
        chk("rand_all_delivered", exp_q.size(), 32'd0);

        // Flush during a threshold burst leaves 3 bytes for a second burst
        for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i));
        lens_q.push_back(4);
        lens_q.push_back(3);
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("fdb_started", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        run_until_idle(60, 1'b0);
        chk("fdb_fifo_drained", fq.size(), 32'd0);

        // Reset after the 2nd beat of a burst
        for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
        lens_q.push_back(4);
        acc0 = accepted;
        n = 0;
        while (accepted < acc0 + 2 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_two_beats_in_budget", {31'd0, n < 20}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_m_data", {24'd0, m_data}, 32'd0);
        chk("mid_rst_m_last", {31'd0, m_last}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_burst_done", {31'd0, burst_done}, 32'd0);
        fq.delete();
        exp_q.delete();
        lens_q.delete();
        beat_idx = 0;
        fifo_counter = '0;
        fifo_empty = 1'b1;
        fifo_data = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, last_busy}, 32'd0);
        for (int i = 0; i < 4; i++) push_byte(8'hE0 + 8'(i));
        lens_q.push_back(4);
        run_until_idle(30, 1'b0);
        chk("post_rst_all_delivered", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
